// File: rtl/mic_capture.sv
// mic_capture: Pmod MIC3 serial front end producing 20 kHz 12-bit samples.
//
// Generates the conversion cadence from the system clock, performs one 16-bit
// SPI read per sample (SCLK idles high, MISO captured on SCLK rise) and
// presents the 12-bit code with a one-cycle strobe.
//
// Ports:
//   clock         system clock, all logic on its rising edge
//   reset         asynchronous active-high reset
//   miso          ADC serial data, treated as synchronous to clock
//   cs_n          ADC chip select, active low
//   sclk          ADC serial clock, idles high
//   sample        most recent 12-bit unsigned conversion, held between strobes
//   sample_valid  one-cycle pulse when sample updates
//   frame_err     leading-zero check result, updated with sample_valid
//
// Build option: define MIC_CAPTURE_LEAD_CHECK_EN to flag frames whose four
// leading bits are not zero; otherwise frame_err is tied low.
module mic_capture #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SAMPLE_HZ = 20_000,
    parameter int HALF_DIV  = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        miso,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        frame_err
);
    localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int HW = $clog2(HALF_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
`ifdef MIC_CAPTURE_LEAD_CHECK_EN
    localparam int SW = 16;
`else
    // Without the check the leading zeros are never looked at, so only the
    // twelve data bits are kept; after 16 shifts they hold the same code.
    localparam int SW = 12;
`endif
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] QUIET = 2'd2;

    // A full frame plus quiet time must fit inside one sample period,
    // otherwise ticks would land outside IDLE and be lost.
    if (33 * HALF_DIV >= SAMPLE_DIV) begin : g_bad_cfg
        $error("mic_capture: 33*HALF_DIV must be less than CLK_HZ/SAMPLE_HZ");
    end

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] half_cnt;
    logic [4:0]    bit_cnt;
    logic [SW-1:0] shreg;
    logic [1:0]    state;
    logic          tick;
    logic          half_done;
    logic          strobe;

    assign tick      = div_cnt == DIV_LAST;
    assign half_done = half_cnt == HALF_LAST;
    assign strobe    = state == QUIET && half_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= CONV;
                        cs_n     <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                CONV: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        sclk     <= ~sclk;
                        // sclk low now means this toggle is a rising edge:
                        // the ADC launched the bit a half-period ago.
                        if (!sclk) begin
                            shreg   <= {shreg[SW-2:0], miso};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd15) begin
                                state <= QUIET;
                                cs_n  <= 1'b1;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                QUIET: begin
                    if (half_done) begin
                        state        <= IDLE;
                        half_cnt     <= '0;
                        sample       <= shreg[11:0];
                        sample_valid <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIC_CAPTURE_LEAD_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       frame_err <= 1'b0;
        else if (strobe) frame_err <= |shreg[15:12];
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_mic_capture.sv
// tb_mic_capture: directed scoreboard bench for mic_capture.
module tb_mic_capture;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        miso;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic        frame_err;

`ifdef MIC_CAPTURE_LEAD_CHECK_EN
    localparam bit LEAD = 1'b1;
`else
    localparam bit LEAD = 1'b0;
`endif

    mic_capture dut (
        .clock(clock),
        .reset(reset),
        .miso(miso),
        .cs_n(cs_n),
        .sclk(sclk),
        .sample(sample),
        .sample_valid(sample_valid),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int errors = 0;
    int strobes = 0;
    int rel_cyc = 0;

    // Frames the ADC model returns, in order, with hand-computed results.
    logic [15:0] frames   [10];
    logic [11:0] exp_samp [10];
    logic        lead_bad [10];
    logic [12:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int t = 0;
        while (strobes < n && t < budget) begin
            @(negedge clock);
            t++;
        end
        check("strobe_count", strobes, n);
    endtask

    // ADC model: bit 15 first, launched on each SCLK fall while selected.
    initial begin
        int idx = 0;
        logic [15:0] word;
        miso = 1'b0;
        forever begin
            @(negedge cs_n);
            word = idx < 10 ? frames[idx] : 16'h0000;
            exp_q.push_back(idx < 10 ? {LEAD & lead_bad[idx], exp_samp[idx]} : 13'h0);
            idx++;
            for (int k = 15; k >= 0; k--) begin
                @(negedge sclk or posedge cs_n);
                if (cs_n) break;
                miso = word[k];
            end
        end
    end

    // Monitor: timing of the SPI frame and scoreboard comparison on strobes.
    int   cs_fall = -1;
    int   last_fall = -1;
    int   last_strobe = -1;
    int   falls = 0;
    bit   first = 1'b1;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b1;
    logic prev_sv = 1'b0;
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                first = 1'b1;
                last_fall = -1;
                last_strobe = -1;
            end else begin
                if (prev_cs && !cs_n) begin
                    if (first) check("first_tick", cyc - rel_cyc, 5000);
                    else if (last_fall >= 0) check("tick_period", cyc - last_fall, 5000);
                    first = 1'b0;
                    cs_fall = cyc;
                    last_fall = cyc;
                    falls = 0;
                end
                if (!cs_n && prev_sclk && !sclk) begin
                    falls++;
                    if (falls == 1) check("first_sclk_fall", cyc - cs_fall, 25);
                end
                if (!prev_cs && cs_n) begin
                    check("cs_low_len", cyc - cs_fall, 800);
                    check("sclk_falls", falls, 16);
                end
                if (prev_sv) check("valid_pulse", sample_valid, 0);
                if (sample_valid) begin
                    strobes++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_strobe: got %0h expected none at cycle %0d", sample, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample", sample, e[11:0]);
                        check("frame_err", frame_err, e[12]);
                    end
                    check("latency", cyc - cs_fall, 825);
                    if (last_strobe >= 0) check("strobe_period", cyc - last_strobe, 5000);
                    last_strobe = cyc;
                end
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
            prev_sv = sample_valid;
        end
    end

    initial begin
        int t;
        logic [12:0] dropped;
        frames   = '{16'h0ABC, 16'h0123, 16'h0456, 16'h0789, 16'h0000,
                     16'h0FFF, 16'hFABC, 16'h0ABC, 16'h0555, 16'h0321};
        exp_samp = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'h000,
                     12'hFFF, 12'hABC, 12'hABC, 12'h555, 12'h321};
        lead_bad = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        repeat (10) @(negedge clock);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        rel_cyc = cyc;
        wait_strobes(8, 42000);
        t = 0;
        do begin
            @(posedge clock);
            #1;
            t++;
        end while (cs_n && t < 6000);
        check("abort_in_conv", cs_n, 0);
        repeat (400) @(posedge clock);
        #1;
        t = 0;
        while (sclk && t < 60) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("abort_sclk_low", sclk, 0);
        reset = 1'b1;
        #1;
        check("abort_cs_n_async", cs_n, 1);
        check("abort_sclk_async", sclk, 1);
        if (exp_q.size() != 0) dropped = exp_q.pop_back();
        repeat (10) @(negedge clock);
        reset = 1'b0;
        rel_cyc = cyc;
        wait_strobes(9, 7000);
        repeat (100) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        check("final_strobes", strobes, 9);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mic_capture.md
# mic_capture

Serial front end for the Pmod MIC3 microphone ADC. It generates the 20 kHz sample cadence from the system clock and runs one 16-bit SPI read per sample. It delivers each 12-bit microphone code with a one-cycle valid strobe. It sits directly upstream of the audio input / volume-metering stage, which consumes `sample` as its mic input.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SAMPLE_HZ`, 20_000, conversion rate. `SAMPLE_DIV = CLK_HZ/SAMPLE_HZ` is 5000 by default.
- `HALF_DIV`, 25, system clocks per SCLK half-period. The default gives SCLK = 2 MHz.
- Constraint: `33*HALF_DIV < SAMPLE_DIV`. This is checked by an elaboration-time assertion.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `miso`  in  1  ADC serial data (MIC3 pin 3). Treated as synchronous to `clock`.
- `cs_n`  out  1  ADC chip select, active low.
- `sclk`  out  1  ADC serial clock. Idles high.
- `sample`  out  12  most recent conversion, unsigned. Held between strobes.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `frame_err`  out  1  leading-zero check result. Valid with `sample_valid` and held until the next strobe.

## Operation
- Rate divider:
  - `div_cnt` counts 0..SAMPLE_DIV-1 and wraps.
  - `tick` is asserted combinationally when `div_cnt == SAMPLE_DIV-1`.
- State machine states: IDLE, CONV, QUIET.
- IDLE:
  - `cs_n=1`, `sclk=1`.
  - On `tick`, go to CONV. In the same edge, `cs_n<=0`, `half_cnt<=0`, `bit_cnt<=0`.
- CONV:
  - `half_cnt` counts 0..HALF_DIV-1. At terminal count, `sclk` toggles and `half_cnt` clears.
  - The first toggle is a falling edge.
  - On each rising toggle (0→1), in the same clock edge: shift `{shreg[14:0], miso}` into `shreg[15:0]`, then increment `bit_cnt`.
  - After the 16th rising toggle, go to QUIET with `cs_n<=1` and `sclk=1`.
- QUIET:
  - Hold for HALF_DIV cycles (ADC quiet time).
  - Then go to IDLE. In that edge: `sample<=shreg[11:0]`, `sample_valid<=1`, and `frame_err` updates.
- `sample_valid` is high for exactly one cycle and low otherwise.
- `shreg[15:12]` are the ADC's four leading zeros. They are not part of `sample`.
- A `tick` arriving outside IDLE is dropped. The constraint makes this unreachable; the bench checks that it never occurs.
- Reset values: `cs_n=1`, `sclk=1`, `sample=12'h000`, `sample_valid=0`, `frame_err=0`, state IDLE, all counters 0, `shreg=0`.
- Reset mid-frame:
  - `cs_n` and `sclk` go high immediately (asynchronously).
  - The partial frame is discarded; no strobe is issued.
  - After release, the next conversion starts on the first `tick`, which is SAMPLE_DIV cycles after release.

## Timing
- First `tick`: SAMPLE_DIV cycles after reset release (cycle 4999 of `div_cnt`).
- `tick` edge to `cs_n` falling: the same edge, 0 cycles.
- `cs_n` low duration: 32*HALF_DIV = 800 cycles, covering 16 full SCLK periods.
- `cs_n` low edge to first `sclk` fall: HALF_DIV = 25 cycles.
- `tick` edge to `sample_valid`: 33*HALF_DIV = 825 cycles.
- Strobe period: exactly SAMPLE_DIV = 5000 cycles (20 kHz).
- `miso` is sampled at the clock edge that raises `sclk`, which gives the ADC a full half-period of setup after its falling-edge launch.

## Configuration
- Macro: `MIC_CAPTURE_LEAD_CHECK_EN`.
- Defined:
  - `frame_err <= (shreg[15:12] != 4'b0000)` at each strobe.
  - `sample` still takes `shreg[11:0]` unchanged.
- Undefined:
  - The check logic is not compiled.
  - `frame_err` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset:** assert `reset` for 10 cycles.
  - During reset: `cs_n=1`, `sclk=1`, `sample=0`, `sample_valid=0`, `frame_err=0`.
  - No `cs_n` fall before cycle 4999 after release.
- **Single conversion:** the ADC model returns 16'h0ABC.
  - `sample=12'hABC` with one `sample_valid` pulse, 825 cycles after `cs_n` falls.
  - Exactly 16 `sclk` falling edges while `cs_n` is low; `cs_n` low for 800 cycles.
- **Cadence:** the model returns 0x0123, 0x0456, 0x0789 on successive frames.
  - Strobes exactly 5000 cycles apart, carrying the matching values.
  - No `tick` is dropped.
- **Extremes:** frames 16'h0000 and 16'h0FFF.
  - `sample=12'h000`, then `12'hFFF`.
  - `frame_err=0` for both.
- **Leading-bit check:** the model returns 16'hFABC.
  - With the macro: `sample=12'hABC`, `frame_err=1`.
  - The next frame, 16'h0ABC, clears `frame_err` to 0.
  - Without the macro: `frame_err` stays 0.
- **Reset mid-frame:** assert `reset` 400 cycles into CONV.
  - `cs_n=1` and `sclk=1` before the next clock edge.
  - No strobe for the aborted frame.
  - The next frame completes normally 825 cycles after its `tick`, with the correct value.
